// File: rtl/sap_ram_prog.sv
// Parametrised SAP-1 program/data RAM. It has a sequenced clear-on-reset engine
// and an edge-strobed program loader that auto-increments its own address.
module sap_ram_prog #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] BusIn,
  input  logic [ADDR_W-1:0] Addrs,
  input  logic              RAMIn,
  input  logic              RAMOut,
  input  logic              ProgMode,
  input  logic              ProgStrobe,
  input  logic [DATA_W-1:0] ProgData,
  output logic [DATA_W-1:0] BusOut,
  output logic              BusOutEn,
  output logic              Busy,
  output logic [ADDR_W-1:0] ProgAddr,
  output logic              ProgWrap
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PROG  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic              strobe_q;
  logic              strobe_rise;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  assign strobe_rise = ProgStrobe & ~strobe_q;
  assign Busy        = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (!clr_n) state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    else        state <= state_next;
  end

  // All memory writes go through one port. The mode selects the source.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = Addrs;
    mem_wdata  = BusIn;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (clr_cnt == LAST_ADDR) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (ProgMode)   state_next = ST_PROG;
        else if (RAMIn) mem_we     = 1'b1;
      end
      ST_PROG: begin
        if (!ProgMode) begin
          state_next = ST_IDLE;
        end else if (strobe_rise) begin
          mem_we    = 1'b1;
          mem_waddr = ProgAddr;
          mem_wdata = ProgData;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      clr_cnt  <= '0;
      BusOut   <= '0;
      BusOutEn <= 1'b0;
      ProgAddr <= '0;
      ProgWrap <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= ProgStrobe;
      ProgWrap <= 1'b0;
      BusOut   <= '0;
      BusOutEn <= 1'b0;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == ST_IDLE && ProgMode) ProgAddr <= '0;
      // The read samples the old word, so a same-address write is read-first.
      if (state == ST_IDLE && !ProgMode && RAMOut) begin
        BusOut   <= mem[Addrs];
        BusOutEn <= 1'b1;
      end
      if (state == ST_PROG && ProgMode && strobe_rise) begin
        ProgAddr <= ProgAddr + 1'b1;
        ProgWrap <= (ProgAddr == LAST_ADDR);
      end
    end
  end

endmodule

// File: doc/sap_ram_prog.md
Name: sap_ram_prog

Overview:
- Parametrised successor to the SAP-1 16x8 program/data RAM.
- Widths and depth are configurable.
- Optionally clears memory to zero on reset, using a sequenced clear engine.
- Adds a program-load mode: an auto-incrementing loader writes words in order without the bus address.
- Sits on the shared 8-bit bus next to the MAR, PC and controller. The controller drives RAMIn/RAMOut; the front-panel loader drives ProgMode/ProgStrobe/ProgData.

Parameters:
- DATA_W, 8, data word width.
- ADDR_W, 4, address width. DEPTH = 2**ADDR_W words, derived internally and not overridable.
- CLEAR_ON_RESET, 1. 1 = zero all words after reset release. 0 = memory contents retained across reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr_n  in  1  synchronous active-low reset.
- BusIn  in  DATA_W  write data from the bus.
- Addrs  in  ADDR_W  word address, from the MAR.
- RAMIn  in  1  run-mode write enable.
- RAMOut  in  1  run-mode read/drive request.
- ProgMode  in  1  1 = program-load mode.
- ProgStrobe  in  1  loader write strobe; edge-detected.
- ProgData  in  DATA_W  loader write data.
- BusOut  out  DATA_W  registered read data; 0 when not driving.
- BusOutEn  out  1  BusOut holds valid read data this cycle.
- Busy  out  1  clear sequence in progress.
- ProgAddr  out  ADDR_W  next loader address.
- ProgWrap  out  1  one-cycle pulse when ProgAddr wraps DEPTH-1 -> 0.

Behaviour:

Reset (clr_n low at a posedge):
- state <= CLEAR if CLEAR_ON_RESET, else IDLE.
- clear counter <= 0.
- BusOut <= 0, BusOutEn <= 0, ProgAddr <= 0, ProgWrap <= 0, strobe history <= 0.
- Busy <= 1 if CLEAR_ON_RESET, else 0.
- Memory is not written while clr_n is low.

CLEAR state:
- Each cycle writes 0 to mem[counter], then counter++.
- Takes exactly DEPTH cycles. After the cycle that writes word DEPTH-1: state <= IDLE, Busy <= 0.
- RAMIn, RAMOut, ProgMode and ProgStrobe are ignored. BusOutEn stays 0.
- Reset mid-clear restarts from word 0 and takes a full DEPTH cycles again.

IDLE (run) state, ProgMode=0:
- RAMIn=1 at a posedge: mem[Addrs] <= BusIn.
- RAMOut=1 at a posedge: BusOut <= mem[Addrs], BusOutEn <= 1. Latency is 1 cycle.
- RAMOut=0: BusOut <= 0, BusOutEn <= 0. Output is zero when idle so the bus may be OR-combined.
- RAMIn=1 and RAMOut=1 on the same address: read-first. BusOut returns the old word; the new word is visible to the next read.
- ProgMode=1 sampled in IDLE:
  - next state PROG, ProgAddr <= 0.
  - RAMIn/RAMOut ignored that cycle; BusOutEn <= 0, BusOut <= 0.

PROG state:
- RAMIn/RAMOut ignored; BusOut/BusOutEn held at 0.
- Rising edge detect: ProgStrobe=1 while the registered previous value is 0.
  - mem[ProgAddr] <= ProgData.
  - ProgAddr <= ProgAddr+1, modulo DEPTH.
- A strobe held high for N cycles performs exactly one write.
- Writing at ProgAddr = DEPTH-1: ProgAddr <= 0 and ProgWrap = 1 for the following cycle only. Otherwise ProgWrap = 0.
- The strobe history register updates every cycle in every state. A strobe already high on PROG entry therefore does not write until it falls and rises again.
- ProgMode=0 sampled in PROG: next state IDLE; no write that cycle. ProgAddr holds its value.
- Reset in PROG: state <= CLEAR/IDLE per CLEAR_ON_RESET, ProgAddr <= 0.

General:
- ProgMode arriving during CLEAR takes effect on the first cycle after IDLE is reached.
- Memory is a plain synchronous array with no read-during-reset side effects.
- All widths derive from DATA_W/ADDR_W; no hard-coded 8 or 4.

Test Plan:
1. Power-up clear (defaults): clr_n low 2 cycles, release.
   -> Busy=1 for exactly 16 cycles, then 0.
   -> RAMOut reads of addrs 0..15 each give BusOut=0x00 with BusOutEn=1 one cycle after request.
2. Write/read: Addrs=2, BusIn=9, RAMIn pulse; then RAMOut=1 at Addrs=2.
   -> next cycle BusOut=0x09, BusOutEn=1.
   -> after RAMOut drops: BusOut=0x00, BusOutEn=0 next cycle.
3. Read-first collision: mem[5]=0x00; RAMIn=RAMOut=1, Addrs=5, BusIn=0x3C.
   -> BusOut=0x00.
   -> following read of addr 5 gives 0x3C.
4. Program load: ProgMode=1, 16 strobes, each held 2 cycles, ProgData=0x10+k.
   -> exactly 16 writes.
   -> ProgWrap single-cycle pulse after the 16th; ProgAddr=0.
   -> run-mode readback of addr k = 0x10+k.
   -> RAMOut during PROG leaves BusOutEn=0.
5. Reset mid-clear: assert clr_n low when the clear counter = 7.
   -> Busy stays high a further full 16 cycles after release.
   -> RAMIn to addr 3 with 0xAA during Busy is ignored; addr 3 reads 0x00 afterwards.
6. CLEAR_ON_RESET=0: preload addr 9=0x55, pulse reset.
   -> Busy never asserts.
   -> addr 9 still reads 0x55.
   -> reset during PROG with ProgAddr=6 returns ProgAddr to 0.
